// File: rtl/cc_action_sched.sv
// Action scheduler: captures a round's action list, issues commands to the board engine one at a
// time, accumulates the returned scores and reports the saturated round total.
module cc_action_sched #(
  parameter int unsigned N_ACT = 10,
  parameter int unsigned WDOG  = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_2,
  input  logic [5:0] in_starting_pos,
  input  logic [1:0] in_action,
  input  logic       board_ready,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [5:0] cmd_pos,
  output logic [1:0] cmd_action,
  input  logic       eng_done,
  input  logic [4:0] eng_score,
  output logic       out_valid,
  output logic [6:0] out_score,
  output logic       busy
);

  localparam int unsigned CW = $clog2(N_ACT + 1);
  localparam int unsigned WW = $clog2(WDOG + 1);

  localparam logic [CW-1:0] NMAX   = CW'(N_ACT);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [WW-1:0] WD_MAX = WW'(WDOG - 1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COLLECT    = 3'd1;
  localparam logic [2:0] S_WAIT_BOARD = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;
  localparam logic [2:0] S_REPORT     = 3'd5;

  logic [2:0]    state;
  logic [5:0]    pos_mem [N_ACT];
  logic [1:0]    act_mem [N_ACT];
  logic [CW-1:0] count;
  logic [CW-1:0] rd_idx;
  logic [6:0]    acc;
  logic [WW-1:0] wd;

  logic       wr_en;
  logic       queue_empty;
  logic [5:0] head_pos;
  logic [1:0] head_act;
  logic [7:0] sum;
  logic [6:0] acc_sat;

  // Entries past N_ACT are dropped because count stops advancing.
  assign wr_en = (state == S_IDLE || state == S_COLLECT) && in_valid_2 && (count < NMAX);

  assign queue_empty = (rd_idx == count);
  assign head_pos    = pos_mem[rd_idx];
  assign head_act    = act_mem[rd_idx];

  assign sum     = {1'b0, acc} + {3'b000, eng_score};
  assign acc_sat = sum[7] ? 7'd127 : sum[6:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pos_mem[count] <= in_starting_pos;
      act_mem[count] <= in_action;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      rd_idx <= '0;
      acc    <= '0;
      wd     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc    <= '0;
          rd_idx <= '0;
          if (in_valid_2) begin
            count <= C_ONE;
            state <= S_COLLECT;
          end else begin
            count <= '0;
          end
        end
        S_COLLECT: begin
          if (in_valid_2) begin
            if (count < NMAX) count <= count + C_ONE;
          end else begin
            state <= S_WAIT_BOARD;
          end
        end
        S_WAIT_BOARD: begin
          rd_idx <= '0;
          if (board_ready) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (queue_empty) begin
            state <= S_REPORT;
          end else if (head_act == 2'd3) begin
            rd_idx <= rd_idx + C_ONE;
          end else if (cmd_ready) begin
            rd_idx <= rd_idx + C_ONE;
            wd     <= '0;
            state  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (eng_done) begin
            acc   <= acc_sat;
            state <= S_ISSUE;
          end else if (wd == WD_MAX) begin
            // Engine hung: abandon the remaining queue and report what we have.
            state <= S_REPORT;
          end else begin
            wd <= wd + W_ONE;
          end
        end
        S_REPORT: begin
          acc   <= '0;
          count <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid  = (state == S_ISSUE) && !queue_empty && (head_act != 2'd3);
    cmd_pos    = cmd_valid ? head_pos : 6'd0;
    cmd_action = cmd_valid ? head_act : 2'd0;
    out_valid  = (state == S_REPORT);
    out_score  = out_valid ? acc : 7'd0;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_cc_action_sched.sv
// Directed bench for cc_action_sched: a scripted engine answers handshakes while scoreboard
// queues hold the expected command stream and round scores.
module tb_cc_action_sched;

  localparam int N_ACT = 10;
  localparam int WDOG  = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_2;
  logic [5:0] in_starting_pos;
  logic [1:0] in_action;
  logic       board_ready;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [5:0] cmd_pos;
  logic [1:0] cmd_action;
  logic       eng_done;
  logic [4:0] eng_score;
  logic       out_valid;
  logic [6:0] out_score;
  logic       busy;

  cc_action_sched #(
    .N_ACT (N_ACT),
    .WDOG  (WDOG)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_2      (in_valid_2),
    .in_starting_pos (in_starting_pos),
    .in_action       (in_action),
    .board_ready     (board_ready),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_pos         (cmd_pos),
    .cmd_action      (cmd_action),
    .eng_done        (eng_done),
    .eng_score       (eng_score),
    .out_valid       (out_valid),
    .out_score       (out_score),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_cmd_q[$];
  int exp_score_q[$];

  int hs_count = 0;
  int out_cnt  = 0;
  int eng_pts  = 0;
  int mute_at  = -1;
  int stall_at = -1;

  logic [5:0] pos_tab [12];
  logic [1:0] act_tab [12];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model and output monitor, all sampled on the falling edge.
  int done_cnt  = 0;
  int stall_cnt = 0;
  int held_cmd  = 0;
  bit chk_next  = 0;
  int got_cmd;

  always @(negedge clk) begin
    eng_done  = 1'b0;
    eng_score = 5'd0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        eng_done  = 1'b1;
        eng_score = 5'(eng_pts);
      end
    end

    cmd_ready = 1'b1;
    got_cmd   = {cmd_pos, cmd_action};
    if (cmd_valid && hs_count == stall_at && stall_cnt < 4) begin
      cmd_ready = 1'b0;
      if (stall_cnt == 0) held_cmd = got_cmd;
      else check("stall_payload_stable", got_cmd, held_cmd);
      stall_cnt++;
    end

    if (cmd_valid && cmd_ready) begin
      if (hs_count == stall_at) check("stall_release_payload", got_cmd, held_cmd);
      check("cmd_expected", exp_cmd_q.size() > 0 ? 1 : 0, 1);
      if (exp_cmd_q.size() > 0) check("cmd_payload", got_cmd, exp_cmd_q.pop_front());
      if (hs_count != mute_at) done_cnt = 5;
      hs_count++;
      stall_cnt = 0;
    end

    if (chk_next) begin
      check("out_valid_one_cycle", int'(out_valid), 0);
      check("out_score_cleared", int'(out_score), 0);
      chk_next = 0;
    end
    if (out_valid) begin
      out_cnt++;
      check("score_expected", exp_score_q.size(), 1);
      if (exp_score_q.size() > 0) check("out_score", int'(out_score), exp_score_q.pop_front());
      chk_next = 1;
    end
  end

  task automatic run_round(input int n, input int pts, input int mute_k, input int stall_k,
                           input int brd_wait);
    int base, obase, issued, answered, exp_sc, limit, guard;
    bit early;
    base     = hs_count;
    obase    = out_cnt;
    eng_pts  = pts;
    mute_at  = (mute_k < 0) ? -1 : base + mute_k;
    stall_at = (stall_k < 0) ? -1 : base + stall_k;
    limit    = (mute_k < 0) ? N_ACT : mute_k + 1;
    issued   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid_2      = 1'b1;
      in_starting_pos = pos_tab[i];
      in_action       = act_tab[i];
      if (i < N_ACT && act_tab[i] != 2'd3 && issued < limit) begin
        exp_cmd_q.push_back({pos_tab[i], act_tab[i]});
        issued++;
      end
    end
    answered = (mute_k >= 0 && issued == limit) ? issued - 1 : issued;
    exp_sc   = answered * pts;
    if (exp_sc > 127) exp_sc = 127;
    exp_score_q.push_back(exp_sc);
    @(negedge clk);
    in_valid_2 = 1'b0;
    if (brd_wait > 0) begin
      early = 0;
      repeat (brd_wait) begin
        @(negedge clk);
        if (cmd_valid) early = 1;
      end
      check("board_wait_no_cmd", int'(early), 0);
      check("board_wait_busy", int'(busy), 1);
      board_ready = 1'b1;
    end
    guard = 0;
    while (out_cnt == obase && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    check("round_reported", out_cnt - obase, 1);
    repeat (2) @(negedge clk);
    check("cmd_count", hs_count - base, issued);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("idle_after_round", int'(busy), 0);
    exp_cmd_q.delete();
    exp_score_q.delete();
    mute_at  = -1;
    stall_at = -1;
  endtask

  initial begin
    int base, obase, guard;
    rst             = 1'b1;
    in_valid_2      = 1'b0;
    in_starting_pos = 6'd0;
    in_action       = 2'd0;
    board_ready     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd_pos", int'(cmd_pos), 0);
    check("rst_cmd_action", int'(cmd_action), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_score", int'(out_score), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Ten swaps, score 3 each.
    for (int i = 0; i < 12; i++) begin
      pos_tab[i] = {3'(i % 6), 3'((i + 2) % 6)};
      act_tab[i] = 2'(i % 2);
    end
    run_round(10, 3, -1, -1, 0);

    // Stall on the second command.
    act_tab[0] = 2'd0; act_tab[1] = 2'd1; act_tab[2] = 2'd2; act_tab[3] = 2'd0;
    run_round(4, 5, -1, 1, 0);

    // Mostly no-ops: only two commands issued.
    act_tab[0] = 2'd3; act_tab[1] = 2'd0; act_tab[2] = 2'd3; act_tab[3] = 2'd3;
    act_tab[4] = 2'd1;
    for (int i = 5; i < 10; i++) act_tab[i] = 2'd3;
    run_round(10, 31, -1, -1, 0);

    // Saturation.
    for (int i = 0; i < 10; i++) act_tab[i] = 2'd2;
    run_round(10, 20, -1, -1, 0);

    // Overlong round with board held back.
    for (int i = 0; i < 12; i++) begin
      pos_tab[i] = {3'((i + 1) % 6), 3'(i % 6)};
      act_tab[i] = 2'((i * 7) % 3);
    end
    board_ready = 1'b0;
    run_round(12, 1, -1, -1, 50);

    // Engine never answers the third command.
    for (int i = 0; i < 5; i++) act_tab[i] = 2'd0;
    run_round(5, 4, 2, -1, 0);

    // All no-ops.
    for (int i = 0; i < 3; i++) act_tab[i] = 2'd3;
    run_round(3, 9, -1, -1, 0);

    // Reset during WAIT_DONE.
    base    = hs_count;
    obase   = out_cnt;
    eng_pts = 9;
    mute_at = base;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_2      = 1'b1;
      in_starting_pos = pos_tab[i];
      in_action       = 2'd1;
      exp_cmd_q.push_back({pos_tab[i], 2'd1});
    end
    @(negedge clk);
    in_valid_2 = 1'b0;
    guard = 0;
    while (hs_count == base && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_run_handshake", hs_count - base, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cmd_valid", int'(cmd_valid), 0);
    check("midrst_cmd_pos", int'(cmd_pos), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_score", int'(out_score), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cmd_q.delete();
    mute_at = -1;
    repeat (30) @(negedge clk);
    check("midrst_no_out_valid", out_cnt - obase, 0);
    check("midrst_no_cmd", hs_count - base, 1);

    // Recovery round after reset.
    act_tab[0] = 2'd0; act_tab[1] = 2'd2;
    run_round(2, 7, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
